// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus between controller and responder, plus the host-side
// TX/RX byte streams and the responder's status outputs.
interface mem_io_responder_if;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_overflow;
    logic        sim_done;

    // Controller / host side
    modport master (
        output addr, wr, wr_data, tx_ready, rx_valid, rx_data,
        input  rd_data, io_buffer_full, tx_valid, tx_data, rx_ready, tx_overflow, sim_done
    );

    // Responder side
    modport slave (
        input  addr, wr, wr_data, tx_ready, rx_valid, rx_data,
        output rd_data, io_buffer_full, tx_valid, tx_data, rx_ready, tx_overflow, sim_done
    );
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the CPU's byte-serial memory bus: byte RAM with one-cycle read
// latency plus an IO window at addr[17:16]==2'b11 (TX/RX FIFOs, status, sim end).
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_WID   = 17,
    parameter int unsigned FIFO_DEPTH_LOG = 4,
    parameter int unsigned FULL_MARGIN    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    mem_io_responder_if.slave bus
);
    localparam int unsigned RAM_SIZE = 1 << RAM_ADDR_WID;
    localparam int unsigned DEPTH    = 1 << FIFO_DEPTH_LOG;
    localparam int unsigned PW       = FIFO_DEPTH_LOG;
    localparam int unsigned CW       = FIFO_DEPTH_LOG + 1;
    localparam logic [17:0] FIFO_ADDR = 18'h30000;
    localparam logic [17:0] CTRL_ADDR = 18'h30004;

    logic [7:0]          ram     [RAM_SIZE];
    logic [7:0]          tx_mem  [DEPTH];
    logic [7:0]          rx_mem  [DEPTH];

    logic [PW-1:0]       tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]       tx_count, rx_count;
    logic [7:0]          rd_data_q;
    logic                io_buffer_full_q;
    logic                tx_overflow_q;
    logic                sim_done_q;

    logic                io_c;
    logic [17:0]         io_off_c;
    logic [RAM_ADDR_WID-1:0] ram_idx_c;
    logic                unused_addr_c;
    logic                tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
    logic                tx_wr_c, tx_pop_c, tx_push_c, tx_drop_c;
    logic                rx_push_c, rx_pop_c;
    logic                sim_wr_c, ram_we_c;
    logic [CW-1:0]       tx_count_next_c, tx_free_next_c;

    // Address decode; bits above 17 only alias
    assign io_c          = (bus.addr[17:16] == 2'b11);
    assign io_off_c      = bus.addr[17:0];
    assign ram_idx_c     = bus.addr[RAM_ADDR_WID-1:0];
    assign unused_addr_c = ^bus.addr[31:18];

    // FIFO status and handshake qualification (everything gated by rdy)
    assign tx_full_c  = (tx_count == CW'(DEPTH));
    assign tx_empty_c = (tx_count == '0);
    assign rx_full_c  = (rx_count == CW'(DEPTH));
    assign rx_empty_c = (rx_count == '0);

    assign tx_wr_c   = rdy && bus.wr && (io_off_c == FIFO_ADDR);
    assign tx_pop_c  = rdy && !tx_empty_c && bus.tx_ready;
    assign tx_push_c = tx_wr_c && (!tx_full_c || tx_pop_c);
    assign tx_drop_c = tx_wr_c && tx_full_c && !tx_pop_c;
    assign rx_push_c = rdy && bus.rx_valid && !rx_full_c;
    assign rx_pop_c  = rdy && !bus.wr && (io_off_c == FIFO_ADDR) && !rx_empty_c;
    assign sim_wr_c  = rdy && bus.wr && (io_off_c == CTRL_ADDR);
    assign ram_we_c  = rdy && bus.wr && !io_c;

    // Near-full flag looks at the count after this edge so the controller's
    // one-cycle sampling lag is absorbed by the margin
    assign tx_count_next_c = tx_count + CW'(tx_push_c) - CW'(tx_pop_c);
    assign tx_free_next_c  = CW'(DEPTH) - tx_count_next_c;

    assign bus.tx_valid       = !tx_empty_c;
    assign bus.tx_data        = tx_mem[tx_rd_ptr];
    assign bus.rx_ready       = !rx_full_c;
    assign bus.rd_data        = rd_data_q;
    assign bus.io_buffer_full = io_buffer_full_q;
    assign bus.tx_overflow    = tx_overflow_q;
    assign bus.sim_done       = sim_done_q;

    // Storage arrays: not reset, written only on qualified pushes/writes
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[ram_idx_c] <= bus.wr_data;
        end
        if (tx_push_c) begin
            tx_mem[tx_wr_ptr] <= bus.wr_data;
        end
        if (rx_push_c) begin
            rx_mem[rx_wr_ptr] <= bus.rx_data;
        end
    end

    // Control state, read data register and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr        <= '0;
            tx_rd_ptr        <= '0;
            tx_count         <= '0;
            rx_wr_ptr        <= '0;
            rx_rd_ptr        <= '0;
            rx_count         <= '0;
            rd_data_q        <= '0;
            io_buffer_full_q <= 1'b0;
            tx_overflow_q    <= 1'b0;
            sim_done_q       <= 1'b0;
        end else begin
            sim_done_q <= sim_wr_c;
            if (rdy) begin
                if (tx_push_c) begin
                    tx_wr_ptr <= tx_wr_ptr + PW'(1);
                end
                if (tx_pop_c) begin
                    tx_rd_ptr <= tx_rd_ptr + PW'(1);
                end
                tx_count         <= tx_count_next_c;
                io_buffer_full_q <= (tx_free_next_c <= CW'(FULL_MARGIN));
                if (tx_drop_c) begin
                    tx_overflow_q <= 1'b1;
                end

                if (rx_push_c) begin
                    rx_wr_ptr <= rx_wr_ptr + PW'(1);
                end
                if (rx_pop_c) begin
                    rx_rd_ptr <= rx_rd_ptr + PW'(1);
                end
                rx_count <= rx_count + CW'(rx_push_c) - CW'(rx_pop_c);

                if (!bus.wr) begin
                    if (!io_c) begin
                        rd_data_q <= ram[ram_idx_c];
                    end else if (io_off_c == FIFO_ADDR) begin
                        rd_data_q <= rx_empty_c ? 8'h00 : rx_mem[rx_rd_ptr];
                    end else if (io_off_c == CTRL_ADDR) begin
                        rd_data_q <= {6'b0, !rx_empty_c, tx_full_c};
                    end else begin
                        rd_data_q <= 8'h00;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, status, rdy freeze, reset.
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   vectors = 0;
    int   miscompares = 0;

    mem_io_responder_if bus();

    mem_io_responder #(
        .RAM_ADDR_WID  (17),
        .FIFO_DEPTH_LOG(4),
        .FULL_MARGIN   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.addr    = 32'h0;
        bus.wr      = 1'b0;
        bus.wr_data = 8'h00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.wr      = 1'b1;
        bus.wr_data = d;
        tick();
        idle();
    endtask

    task automatic bus_read(input logic [31:0] a);
        bus.addr = a;
        bus.wr   = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick();
        tick();
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        vectors++; if (bus.io_buffer_full !== 1'b0) begin miscompares++; $display("FAIL reset_io_buffer_full: got %b want 0", bus.io_buffer_full); end
        vectors++; if (bus.tx_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_tx_overflow: got %b want 0", bus.tx_overflow); end
        vectors++; if (bus.sim_done !== 1'b0) begin miscompares++; $display("FAIL reset_sim_done: got %b want 0", bus.sim_done); end
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        vectors++; if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
        rst = 1'b0;
    endtask

    task automatic test_ram();
        bus_write(32'h0000_0123, 8'hA5);
        bus_write(32'h0001_0123, 8'h5A);
        bus.addr = 32'h0000_0123;
        tick();
        vectors++; if (bus.rd_data !== 8'hA5) begin miscompares++; $display("FAIL ram_read_00123: got %h want a5", bus.rd_data); end
        bus.addr = 32'h0001_0123;
        tick();
        vectors++; if (bus.rd_data !== 8'h5A) begin miscompares++; $display("FAIL ram_read_10123: got %h want 5a", bus.rd_data); end
        bus.addr = 32'h0000_0123;
        #1;
        vectors++; if (bus.rd_data !== 8'h5A) begin miscompares++; $display("FAIL ram_latency_hold: got %h want 5a", bus.rd_data); end
        tick();
        vectors++; if (bus.rd_data !== 8'hA5) begin miscompares++; $display("FAIL ram_latency_update: got %h want a5", bus.rd_data); end
        bus.addr = 32'hFFFC_0123;
        tick();
        vectors++; if (bus.rd_data !== 8'hA5) begin miscompares++; $display("FAIL ram_high_alias: got %h want a5", bus.rd_data); end
        idle();
    endtask

    task automatic test_tx();
        bus.tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h48);
        bus_write(32'h0003_0000, 8'h69);
        vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h48) begin miscompares++; $display("FAIL tx_head_H: valid=%b data=%h want 1/48", bus.tx_valid, bus.tx_data); end
        bus.tx_ready = 1'b1;
        tick();
        vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h69) begin miscompares++; $display("FAIL tx_head_i: valid=%b data=%h want 1/69", bus.tx_valid, bus.tx_data); end
        tick();
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_empty_after_drain: valid=%b want 0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [7:0] exp;
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            bus_write(32'h0003_0000, 8'(8'h10 + i));
            if (i == 13) begin
                vectors++; if (bus.io_buffer_full !== 1'b0) begin miscompares++; $display("FAIL full_after_13: got %b want 0", bus.io_buffer_full); end
            end
            if (i == 14) begin
                vectors++; if (bus.io_buffer_full !== 1'b1) begin miscompares++; $display("FAIL full_after_14: got %b want 1", bus.io_buffer_full); end
            end
        end
        vectors++; if (bus.tx_overflow !== 1'b0) begin miscompares++; $display("FAIL no_overflow_at_16: got %b want 0", bus.tx_overflow); end
        bus_read(32'h0003_0004);
        vectors++; if (bus.rd_data !== 8'h01) begin miscompares++; $display("FAIL status_tx_full: got %h want 01", bus.rd_data); end
        // push into a full FIFO while popping
        bus.tx_ready = 1'b1;
        bus.addr     = 32'h0003_0000;
        bus.wr       = 1'b1;
        bus.wr_data  = 8'hEE;
        tick();
        bus.tx_ready = 1'b0;
        idle();
        vectors++; if (bus.tx_overflow !== 1'b0) begin miscompares++; $display("FAIL push_pop_full_overflow: got %b want 0", bus.tx_overflow); end
        vectors++; if (bus.tx_data !== 8'h12 || bus.io_buffer_full !== 1'b1) begin miscompares++; $display("FAIL push_pop_full_head: data=%h full=%b want 12/1", bus.tx_data, bus.io_buffer_full); end
        bus_read(32'h0003_0004);
        vectors++; if (bus.rd_data !== 8'h01) begin miscompares++; $display("FAIL status_still_full: got %h want 01", bus.rd_data); end
        bus_write(32'h0003_0000, 8'h77);
        vectors++; if (bus.tx_overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_17th: got %b want 1", bus.tx_overflow); end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(8'h12 + i) : 8'hEE;
            vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin miscompares++; $display("FAIL full_drain_%0d: valid=%b data=%h want 1/%h", i, bus.tx_valid, bus.tx_data, exp); end
            tick();
        end
        bus.tx_ready = 1'b0;
        vectors++; if (bus.tx_valid !== 1'b0 || bus.io_buffer_full !== 1'b0) begin miscompares++; $display("FAIL full_drained: valid=%b full=%b want 0/0", bus.tx_valid, bus.io_buffer_full); end
    endtask

    task automatic test_rx();
        bus_read(32'h0000_0123);
        bus_read(32'h0003_0000);
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rx_empty_read: got %h want 00", bus.rd_data); end
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h31;
        tick();
        bus.rx_valid = 1'b0;
        bus_read(32'h0003_0004);
        vectors++; if (bus.rd_data !== 8'h02) begin miscompares++; $display("FAIL rx_status_nonempty: got %h want 02", bus.rd_data); end
        bus_read(32'h0003_0000);
        vectors++; if (bus.rd_data !== 8'h31) begin miscompares++; $display("FAIL rx_pop_31: got %h want 31", bus.rd_data); end
        bus_read(32'h0003_0004);
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rx_status_empty: got %h want 00", bus.rd_data); end
        // pop of an empty FIFO while a byte arrives
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h44;
        bus.addr     = 32'h0003_0000;
        tick();
        bus.rx_valid = 1'b0;
        idle();
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rx_simul_rd: got %h want 00", bus.rd_data); end
        bus_read(32'h0003_0000);
        vectors++; if (bus.rd_data !== 8'h44) begin miscompares++; $display("FAIL rx_simul_enq: got %h want 44", bus.rd_data); end
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rx_data = 8'(8'h50 + i);
            tick();
        end
        bus.rx_data = 8'h99;
        vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL rx_full_ready: got %b want 0", bus.rx_ready); end
        tick();
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_read(32'h0003_0000);
            vectors++; if (bus.rd_data !== 8'(8'h50 + i)) begin miscompares++; $display("FAIL rx_drain_%0d: got %h want %h", i, bus.rd_data, 8'(8'h50 + i)); end
        end
        bus_read(32'h0003_0004);
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rx_full_drop: got %h want 00", bus.rd_data); end
    endtask

    task automatic test_rdy();
        bus.tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h01);
        bus_write(32'h0003_0000, 8'h02);
        bus_write(32'h0003_0000, 8'h03);
        bus_write(32'h0000_0200, 8'h11);
        bus_read(32'h0000_0123);
        rdy          = 1'b0;
        bus.addr     = 32'h0000_0200;
        bus.wr       = 1'b1;
        bus.wr_data  = 8'hCC;
        bus.tx_ready = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5E;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h01) begin miscompares++; $display("FAIL rdy_freeze_tx_%0d: valid=%b data=%h want 1/01", i, bus.tx_valid, bus.tx_data); end
        end
        vectors++; if (bus.rd_data !== 8'hA5) begin miscompares++; $display("FAIL rdy_hold_rd_data: got %h want a5", bus.rd_data); end
        rdy          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        idle();
        bus_read(32'h0000_0200);
        vectors++; if (bus.rd_data !== 8'h11) begin miscompares++; $display("FAIL rdy_no_ram_write: got %h want 11", bus.rd_data); end
        bus_read(32'h0003_0004);
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rdy_no_rx_push: got %h want 00", bus.rd_data); end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i + 1)) begin miscompares++; $display("FAIL rdy_resume_%0d: valid=%b data=%h want 1/%h", i, bus.tx_valid, bus.tx_data, 8'(i + 1)); end
            tick();
        end
        bus.tx_ready = 1'b0;
        vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rdy_resume_empty: valid=%b want 0", bus.tx_valid); end
    endtask

    task automatic test_reset_mid();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus_write(32'h0003_0000, 8'(i));
        end
        bus.tx_ready = 1'b1;
        repeat (11) tick();
        bus.tx_ready = 1'b0;
        vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h0B || bus.tx_overflow !== 1'b1) begin miscompares++; $display("FAIL pre_reset_state: valid=%b data=%h ovf=%b want 1/0b/1", bus.tx_valid, bus.tx_data, bus.tx_overflow); end
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rx_data = 8'(8'h80 + i);
            tick();
        end
        bus.rx_valid = 1'b0;
        vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL pre_reset_rx_full: got %b want 0", bus.rx_ready); end
        bus_read(32'h0000_0123);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (bus.tx_valid !== 1'b0 || bus.io_buffer_full !== 1'b0) begin miscompares++; $display("FAIL mid_reset_tx: valid=%b full=%b want 0/0", bus.tx_valid, bus.io_buffer_full); end
        vectors++; if (bus.tx_overflow !== 1'b0 || bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_flags: ovf=%b rx_ready=%b want 0/1", bus.tx_overflow, bus.rx_ready); end
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL mid_reset_rd_data: got %h want 00", bus.rd_data); end
        bus_read(32'h0003_0004);
        vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL mid_reset_status: got %h want 00", bus.rd_data); end
        bus_write(32'h0003_0008, 8'h55);
        vectors++; if (bus.sim_done !== 1'b0 || bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL other_io_write: sim_done=%b tx_valid=%b want 0/0", bus.sim_done, bus.tx_valid); end
        bus_write(32'h0003_0004, 8'h00);
        vectors++; if (bus.sim_done !== 1'b1) begin miscompares++; $display("FAIL sim_done_pulse: got %b want 1", bus.sim_done); end
        tick();
        vectors++; if (bus.sim_done !== 1'b0) begin miscompares++; $display("FAIL sim_done_clear: got %b want 0", bus.sim_done); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx();
        test_full();
        test_rx();
        test_rdy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sequence did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Slave end of the CPU's byte-serial memory bus, i.e. the responder for the memory controller's mem_a/mem_wr/mem_dout/mem_din interface.
- Provides byte-addressed RAM with a one-cycle read latency.
- Provides a memory-mapped IO window at addr[17:16]==2'b11: TX FIFO toward the host, RX FIFO from the host, status byte, and simulation-end register.
- Drives io_buffer_full, which the controller uses to stall IO stores.

Parameters:
- RAM_ADDR_WID, 17, RAM address bits; RAM holds 2^RAM_ADDR_WID bytes.
- FIFO_DEPTH_LOG, 4, log2 depth of each of the TX and RX FIFOs (default 16 entries).
- FULL_MARGIN, 2, io_buffer_full asserts when free TX slots <= FULL_MARGIN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; when low, all state is frozen
- addr  in  32  byte address from controller (controller's mem_a)
- wr  in  1  1 = write this cycle (controller's mem_wr)
- wr_data  in  8  write byte (controller's mem_dout)
- rd_data  out  8  read byte (controller's mem_din); registered
- io_buffer_full  out  1  TX FIFO near full; registered
- tx_valid  out  1  TX FIFO head valid
- tx_data  out  8  TX FIFO head byte
- tx_ready  in  1  host accepts the head byte
- rx_valid  in  1  host offers a byte
- rx_data  in  8  offered byte
- rx_ready  out  1  RX FIFO not full
- tx_overflow  out  1  sticky: an IO write was dropped because TX was full
- sim_done  out  1  one-cycle pulse on a write to 0x30004

Behaviour:
- Decode: io = (addr[17:16]==2'b11); RAM index = addr[RAM_ADDR_WID-1:0]. Bits above 17 are ignored.
- Reset values:
  - rd_data=0, io_buffer_full=0, tx_overflow=0, sim_done=0.
  - Both FIFOs empty, so tx_valid=0 and rx_ready=1.
  - RAM contents are not cleared.
  - Reset mid-transfer discards both FIFOs.
- rdy=0:
  - No RAM write, no FIFO push or pop, rd_data held.
  - rx_ready and tx_valid reflect the frozen FIFO state; handshakes are ignored.
- RAM write: on the edge where wr=1 and !io, ram[index] <= wr_data.
- RAM read:
  - On every edge with wr=0 and !io, rd_data <= ram[index].
  - Data is therefore valid in the cycle after the address is presented.
  - Read-during-write to the same address is not possible, because wr=1 implies no read.
- IO write, addr==0x30000:
  - Push wr_data into TX.
  - If TX is full, drop the byte and set tx_overflow (sticky until rst).
- IO write, addr==0x30004: sim_done=1 for exactly one cycle.
- Other IO writes are ignored.
- IO read, addr==0x30000 with wr=0:
  - Pop RX; rd_data <= head, or 0x00 if RX is empty.
  - Pops once per cycle the address is presented. The controller presents an IO read address for exactly one cycle.
- IO read, addr==0x30004: rd_data <= {6'b0, rx_nonempty, tx_full}.
- Other IO reads return 0.
- TX FIFO:
  - Pop on tx_valid && tx_ready; tx_data = head (combinational from the array).
  - Push and pop in the same cycle: count unchanged; a push into a full FIFO with a simultaneous pop succeeds.
- RX FIFO:
  - Push on rx_valid && rx_ready, with rx_ready = !rx_full.
  - Simultaneous push and pop (IO read of an empty FIFO while rx_valid): rd_data=0 and the byte is enqueued.
- Pointers are FIFO_DEPTH_LOG bits and wrap modulo depth; count is FIFO_DEPTH_LOG+1 bits.
- io_buffer_full:
  - Registered from the next-state count: asserted when depth - tx_count_next <= FULL_MARGIN.
  - The margin covers the controller's one-cycle sampling lag; with FULL_MARGIN>=2 a well-behaved controller never overflows.

Test Plan:
- RAM round trip: write 0xA5 to 0x00123, then present a read of 0x00123 → rd_data=0xA5 exactly one cycle later; 0x10123 (aliased bit 16 only, not IO) reads its own byte.
- TX path: tx_ready=0, write 'H','i' to 0x30000 → tx_valid=1, tx_data=0x48; raise tx_ready → 0x48 then 0x69 over 2 cycles, then tx_valid=0.
- Full threshold: tx_ready=0, write 14 bytes → io_buffer_full=1 after the 14th; 17th write → dropped, tx_overflow=1; tx_ready for 1 cycle with a simultaneous write → count stays 16, no overflow.
- RX: read 0x30000 when empty → rd_data=0x00; push 0x31 via rx_valid, read 0x30004 → 0x02; read 0x30000 → 0x31; 0x30004 → 0x00.
- rdy=0 for 3 cycles during RAM write + TX drain → no RAM change, no TX pop; resume identical to uninterrupted run.
- rst asserted with 5 bytes in TX and tx_overflow=1 → next cycle tx_valid=0, io_buffer_full=0, tx_overflow=0, rx_ready=1; write 0x30004 → sim_done pulses one cycle.
